// File: rtl/cmd_transmitter_pkg.sv
// cmd_transmitter_pkg: command word layout, section codes and FSM encoding
package cmd_transmitter_pkg;
  localparam logic [1:0] SECTION_MEM = 2'b00;
  localparam logic [1:0] SECTION_DOT = 2'b01;
  localparam logic [1:0] SECTION_CFG = 2'b10;
  localparam logic [1:0] SECTION_RUN = 2'b11;
  localparam int CMD_W    = 32;
  localparam int SEC_LSB  = 30;
  localparam int SEC_W    = 2;
  localparam int TGT_LSB  = 26;
  localparam int TGT_W    = 4;
  localparam int MASK_LSB = 23;
  localparam int MASK_W   = 3;
  localparam int ADDR_LSB = 16;
  localparam int ADDR_W   = 7;
  localparam int DATA_LSB = 0;
  localparam int DATA_W   = 16;
  typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_LATCH, ST_GAP} state_e;
  typedef struct packed {
    logic [SEC_W-1:0]  section;
    logic [TGT_W-1:0]  target;
    logic [MASK_W-1:0] mask;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              broadcast;
  } req_t;
  function automatic logic [CMD_W-1:0] pack_cmd(input req_t r, input logic [TGT_W-1:0] tgt);
    pack_cmd = {r.section, tgt, r.mask, r.addr, r.data};
  endfunction
endpackage

// File: rtl/cmd_transmitter_fifo.sv
// cmd_fifo: synchronous FIFO with occupancy count and async active-low reset
module cmd_fifo #(
  parameter int W     = 33,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);
  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q;
  logic          do_push, do_pop;
  assign full    = cnt_q == (AW+1)'(DEPTH);
  assign empty   = cnt_q == '0;
  assign count   = cnt_q;
  assign rdata   = mem_q[rd_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop) rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
  // storage needs no reset: a flush only clears the pointers
  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_q] <= wdata;
  end
endmodule

// File: rtl/cmd_transmitter.sv
// cmd_transmitter: buffers host command requests and strobes them out as packed words
module cmd_transmitter
  import cmd_transmitter_pkg::*;
#(
  parameter int NUM_OF_DRIVERS = 16,
  parameter int FIFO_DEPTH     = 4,
  parameter int LATCH_CYCLES   = 2,
  parameter int GAP_CYCLES     = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_section,
  input  logic [3:0]  req_target,
  input  logic [2:0]  req_mask,
  input  logic [6:0]  req_addr,
  input  logic [15:0] req_data,
  input  logic        req_broadcast,
  output logic [31:0] cmd_data,
  output logic        latch_data,
  output logic        busy,
  output logic [15:0] issued_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  req_t              wr_req, head;
  logic              fifo_full, fifo_empty, pop;
  logic [AW:0]       fifo_count;
  logic              head_bc;
  logic [CMD_W-1:0]  head_cmd;
  state_e            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [TGT_W-1:0]  bc_q, bc_d;
  logic              bc_act_q, bc_act_d;
  logic [CMD_W-1:0]  cmd_q, cmd_d;
  logic              latch_q;
  logic [15:0]       issued_q, issued_d;
  assign wr_req = {req_section, req_target, req_mask, req_addr, req_data, req_broadcast};
  cmd_fifo #(.W($bits(req_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (req_valid && req_ready),
    .pop     (pop),
    .wdata   (wr_req),
    .rdata   (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );
  assign req_ready    = !fifo_full;
  assign busy         = fifo_count != '0 || state_q != ST_IDLE;
  assign cmd_data     = cmd_q;
  assign latch_data   = latch_q;
  assign issued_count = issued_q;
  // run commands carry a control state in the target field, so they never expand
  assign head_bc  = head.broadcast && head.section != SECTION_RUN;
  assign head_cmd = pack_cmd(head, head_bc ? '0 : head.target);
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bc_d     = bc_q;
    bc_act_d = bc_act_q;
    cmd_d    = cmd_q;
    issued_d = issued_q;
    pop      = 1'b0;
    unique case (state_q)
      ST_IDLE: if (!fifo_empty) begin
        pop      = 1'b1;
        cmd_d    = head_cmd;
        bc_act_d = head_bc;
        bc_d     = '0;
        state_d  = ST_SETUP;
      end
      ST_SETUP: begin
        cnt_d   = '0;
        state_d = ST_LATCH;
      end
      ST_LATCH: if (cnt_q == 8'(LATCH_CYCLES - 1)) begin
        cnt_d    = '0;
        issued_d = issued_q + 1'b1;
        state_d  = ST_GAP;
      end else cnt_d = cnt_q + 1'b1;
      ST_GAP: if (cnt_q == 8'(GAP_CYCLES - 1)) begin
        if (bc_act_q && bc_q != TGT_W'(NUM_OF_DRIVERS - 1)) begin
          bc_d                         = bc_q + 1'b1;
          cmd_d[TGT_LSB +: TGT_W]      = bc_q + 1'b1;
          state_d                      = ST_SETUP;
        end else if (!fifo_empty) begin
          pop      = 1'b1;
          cmd_d    = head_cmd;
          bc_act_d = head_bc;
          bc_d     = '0;
          state_d  = ST_SETUP;
        end else begin
          bc_act_d = 1'b0;
          state_d  = ST_IDLE;
        end
      end else cnt_d = cnt_q + 1'b1;
      default: state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      bc_q     <= '0;
      bc_act_q <= 1'b0;
      cmd_q    <= '0;
      latch_q  <= 1'b0;
      issued_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bc_q     <= bc_d;
      bc_act_q <= bc_act_d;
      cmd_q    <= cmd_d;
      latch_q  <= state_d == ST_LATCH;
      issued_q <= issued_d;
    end
  end
endmodule

// File: tb/tb_cmd_transmitter.sv
// tb_cmd_transmitter: directed stimulus against a word-queue model of the command stream
module tb_cmd_transmitter;
  localparam int LAT    = 2;
  localparam int GAPC   = 2;
  localparam int PERIOD = 1 + LAT + GAPC;
  logic        clock = 0, reset_n = 0, req_valid = 0, req_broadcast = 0;
  logic [1:0]  req_section = '0;
  logic [3:0]  req_target = '0;
  logic [2:0]  req_mask = '0;
  logic [6:0]  req_addr = '0;
  logic [15:0] req_data = '0;
  logic        req_ready, latch_data, busy;
  logic [31:0] cmd_data;
  logic [15:0] issued_count;

  cmd_transmitter dut (
    .clock(clock), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_section(req_section), .req_target(req_target), .req_mask(req_mask),
    .req_addr(req_addr), .req_data(req_data), .req_broadcast(req_broadcast),
    .cmd_data(cmd_data), .latch_data(latch_data), .busy(busy), .issued_count(issued_count)
  );

  always #5 clock = ~clock;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int checks = 0, errors = 0;
  logic [31:0] expq[$];
  logic [31:0] rw[$];
  int          rc[$];
  logic [15:0] m_issued = '0;
  logic        pl = 0, pb = 0;
  logic [31:0] pc = '0;
  int hi = 0, sf = GAPC, bfall = 0, lfall = 0, acc_cyc = 0, stalls = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, want);
    end
  endtask

  // model: each accepted request becomes one or N words that must appear in order
  always @(negedge clock) begin
    if (!reset_n) begin
      expq.delete();
      m_issued = '0; pl = 0; pc = '0; hi = 0; sf = GAPC; pb = 0;
    end else begin
      if (latch_data && !pl) begin
        check("pulse_pending", 32'(expq.size() != 0), 1);
        if (expq.size() != 0) check("word", cmd_data, expq[0]);
        check("setup_stable", cmd_data, pc);
        if (rc.size() > 0) check("rise_spacing", 32'(cyc - rc[$] >= PERIOD), 1);
        rc.push_back(cyc);
        rw.push_back(cmd_data);
        hi = 1;
      end else if (latch_data) begin
        check("hold_stable", cmd_data, pc);
        hi++;
      end
      if (!latch_data && pl) begin
        check("pulse_len", 32'(hi), LAT);
        if (expq.size() != 0) void'(expq.pop_front());
        m_issued++;
        lfall = cyc;
        sf = 0;
      end else if (!latch_data && sf < GAPC) sf++;
      check("issued", 32'(issued_count), 32'(m_issued));
      check("busy", 32'(busy), 32'(expq.size() != 0 || latch_data || sf < GAPC));
      if (pb && !busy) bfall = cyc;
      pl = latch_data; pc = cmd_data; pb = busy;
    end
  end

  task automatic push(input logic [1:0] s, input logic [3:0] t, input logic [2:0] m,
                      input logic [6:0] a, input logic [15:0] d, input logic b);
    req_section = s; req_target = t; req_mask = m; req_addr = a; req_data = d;
    req_broadcast = b; req_valid = 1;
    stalls = 0;
    while (!req_ready && stalls < 50) begin
      @(posedge clock); #1;
      stalls++;
    end
    if (!req_ready) check("push_timeout", 32'(req_ready), 1);
    else begin
      @(posedge clock); #1;
      acc_cyc = cyc;
      if (b && s != 2'b11) for (int i = 0; i < 16; i++) expq.push_back({s, 4'(i), m, a, d});
      else expq.push_back({s, t, m, a, d});
    end
  endtask

  task automatic drop();
    req_valid = 0;
    req_broadcast = 0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clock);
    while (busy && n < 400) begin
      @(negedge clock);
      n++;
    end
    check("idle_timeout", 32'(busy), 0);
    @(posedge clock); #1;
  endtask

  task automatic do_reset();
    @(posedge clock); #2 reset_n = 0;
    repeat (2) @(posedge clock);
    #3 reset_n = 1;
    @(posedge clock); #1;
  endtask

  int n0, k, ae, af, st, w;
  logic [31:0] tmp;
  initial begin
    #12;
    check("rst_cmd", cmd_data, 0);
    check("rst_latch", 32'(latch_data), 0);
    check("rst_issued", 32'(issued_count), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_ready", 32'(req_ready), 1);
    #6 reset_n = 1;
    @(posedge clock); #1;

    n0 = rc.size();
    push(2'b00, 4'd3, 3'd5, 7'h12, 16'hBEEF, 0);
    drop();
    k = acc_cyc;
    wait_idle();
    check("single_pulses", 32'(rc.size() - n0), 1);
    check("single_word", rc.size() > n0 ? rw[n0] : 'x, 32'h0E92BEEF);
    check("single_latency", rc.size() > n0 ? 32'(rc[n0] - k) : 'x, 2);
    check("single_high", rc.size() > n0 ? 32'(lfall - rc[n0]) : 'x, 2);
    check("single_issued", 32'(issued_count), 1);

    n0 = rc.size();
    push(2'b01, 4'd1, 3'd1, 7'h01, 16'h1111, 0);
    push(2'b10, 4'd2, 3'd2, 7'h42, 16'h2222, 0);
    push(2'b00, 4'd15, 3'd7, 7'h7F, 16'hFFFF, 0);
    drop();
    wait_idle();
    check("b2b_pulses", 32'(rc.size() - n0), 3);
    check("b2b_gap1", rc.size() > n0 + 2 ? 32'(rc[n0+1] - rc[n0]) : 'x, PERIOD);
    check("b2b_gap2", rc.size() > n0 + 2 ? 32'(rc[n0+2] - rc[n0+1]) : 'x, PERIOD);
    check("b2b_busy_drop", 32'(bfall - lfall), 2);

    n0 = rc.size();
    for (int i = 0; i < 5; i++) push(2'b00, 4'(i), 3'd0, 7'(i), 16'(16'hA000 + i), 0);
    ae = acc_cyc;
    check("full_ready_low", 32'(req_ready), 0);
    push(2'b00, 4'd5, 3'd0, 7'd5, 16'hA005, 0);
    af = acc_cyc; st = stalls;
    drop();
    wait_idle();
    check("full_stalls", 32'(st), 2);
    check("full_accept_gap", 32'(af - ae), 3);
    check("full_pulses", 32'(rc.size() - n0), 6);

    do_reset();
    n0 = rc.size();
    push(2'b01, 4'd9, 3'd2, 7'h05, 16'h1234, 1);
    push(2'b00, 4'd6, 3'd1, 7'h40, 16'hAAAA, 0);
    drop();
    wait_idle();
    check("bc_pulses", 32'(rc.size() - n0), 17);
    check("bc_first", rc.size() > n0 ? rw[n0] : 'x, 32'h41051234);
    tmp = rc.size() > n0 + 15 ? rw[n0+15] : 'x;
    check("bc_last_tgt", 32'(tmp[29:26]), 15);
    check("bc_next_entry", rc.size() > n0 + 16 ? rw[n0+16] : 'x, 32'h18C0AAAA);
    check("bc_issued", 32'(issued_count), 17);

    n0 = rc.size();
    push(2'b11, 4'b1010, 3'd0, 7'h00, 16'h0001, 1);
    drop();
    wait_idle();
    check("run_pulses", 32'(rc.size() - n0), 1);
    tmp = rc.size() > n0 ? rw[n0] : 'x;
    check("run_head", 32'(tmp[31:26]), 32'(6'b111010));

    n0 = rc.size();
    push(2'b00, 4'd1, 3'd1, 7'h11, 16'h0101, 0);
    push(2'b00, 4'd2, 3'd2, 7'h22, 16'h0202, 0);
    push(2'b00, 4'd3, 3'd3, 7'h33, 16'h0303, 0);
    drop();
    w = 0;
    @(negedge clock);
    while (!latch_data && w < 20) begin
      @(negedge clock);
      w++;
    end
    check("mid_latch_seen", 32'(latch_data), 1);
    @(posedge clock); #2 reset_n = 0;
    #1;
    check("mid_latch", 32'(latch_data), 0);
    check("mid_cmd", cmd_data, 0);
    check("mid_issued", 32'(issued_count), 0);
    check("mid_ready", 32'(req_ready), 1);
    check("mid_busy", 32'(busy), 0);
    @(posedge clock); #3 reset_n = 1;
    repeat (15) @(posedge clock);
    #1;
    check("mid_discard", 32'(rc.size() - n0), 1);
    check("mid_idle", 32'(busy), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/cmd_transmitter.md
# cmd_transmitter

Host-side transmitter for the sequencer command port. It accepts field-level command requests through a valid/ready handshake and buffers them in a small FIFO. Each request is packed into the 32-bit command word and presented on `cmd_data`, with a level pulse on `latch_data` that meets the receiver's setup, hold and spacing rules. It sits between the host register/bus logic and `system_controller`; its `cmd_data` and `latch_data` outputs connect directly to that block's inputs.

## Interface
- `NUM_OF_DRIVERS`, 16: number of sequencer targets; broadcast iterates 0..NUM_OF_DRIVERS-1 (max 16).
- `FIFO_DEPTH`, 4: request buffer entries, power of two, ≥2.
- `LATCH_CYCLES`, 2: cycles `latch_data` is held high per command, ≥1.
- `GAP_CYCLES`, 2: minimum low cycles between consecutive `latch_data` pulses, ≥1.

Ports:
- `clock` in 1: single clock.
- `reset_n` in 1: asynchronous active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: `!fifo_full`, combinational from the FIFO count.
- `req_section` in 2: command section; 00 mem, 01 dot, 10 config/sel, 11 run.
- `req_target` in 4: sequencer select, or control state for section 11.
- `req_mask` in 3: data mask.
- `req_addr` in 7: address; bit 6 is the mem/config select for section 10.
- `req_data` in 16: payload.
- `req_broadcast` in 1: issue to every target.
- `cmd_data` out 32: packed command word.
- `latch_data` out 1: latch strobe, a level pulse.
- `busy` out 1: FIFO non-empty or FSM not IDLE.
- `issued_count` out 16: commands transmitted, wraps at 16'hFFFF→0.

## Operation
- Packing: `cmd_data` = {section[31:30], target[29:26], mask[25:23], addr[22:16], data[15:0]}.
- Push: when `req_valid && req_ready`, the request fields and the broadcast flag are written into the FIFO.
- No push occurs when full. A pop in the same cycle does not raise `req_ready` until the next cycle.
- FSM states: IDLE, SETUP, LATCH, GAP.
- IDLE: if the FIFO is non-empty, pop the head, load `cmd_data`, go to SETUP.
- SETUP: one cycle with `latch_data` low; `cmd_data` is stable. Go to LATCH.
- LATCH: `latch_data` high for LATCH_CYCLES cycles. On exit, increment `issued_count` and go to GAP.
- GAP: `latch_data` low for GAP_CYCLES cycles. On exit:
  - pending broadcast target → load the next word, go to SETUP;
  - else FIFO non-empty → pop, load, go to SETUP;
  - else → IDLE.
- `cmd_data` changes only on a load, i.e. on entry to SETUP. It is held through LATCH, GAP and IDLE.
- Broadcast, sections 00/01/10: `req_target` is ignored. The entry expands into NUM_OF_DRIVERS commands with target 0,1,…,N-1 in order. It is popped from the FIFO once, at the first load.
- Broadcast with section 11: flag ignored; a single command is issued with `req_target` unchanged.
- Reset (asynchronous, any time): FIFO flushed, FSM→IDLE, broadcast counter cleared.
- Reset values: `cmd_data`=0, `latch_data`=0, `issued_count`=0, `busy`=0, `req_ready`=1.

## Timing
- Empty FIFO, FSM in IDLE, push accepted at edge k:
  - FIFO non-empty after k;
  - `cmd_data` valid after edge k+1;
  - `latch_data` rises after edge k+2;
  - `latch_data` falls after edge k+2+LATCH_CYCLES.
- Back-to-back commands: period 1+LATCH_CYCLES+GAP_CYCLES cycles (5 at defaults).
- `cmd_data` is stable ≥1 cycle before the `latch_data` rise and throughout the pulse.
- `latch_data` is registered and glitch-free.
- `issued_count` updates on the edge where `latch_data` falls.

## Structure
- Shared package holds:
  - section constants (SECTION_MEM, SECTION_DOT, SECTION_CFG, SECTION_RUN);
  - field bit positions and widths of the 32-bit command word;
  - the FSM state encoding.
- The receiver side imports the same field positions.
- One sub-module: `cmd_fifo`, a synchronous FIFO with count, full/empty, async active-low reset and a width parameter.
- FSM, packing and broadcast counter live in `cmd_transmitter`.

## Test plan
- Single command: push section 00, target 3, mask 5, addr 7'h12, data 16'hBEEF.
  - `cmd_data`=32'h0E92BEEF one cycle before `latch_data` rises.
  - `latch_data` high 2 cycles.
  - `issued_count`=1.
- Back-to-back: push 3 commands on consecutive cycles.
  - Three pulses, rising edges exactly 5 cycles apart.
  - Words in push order.
  - `busy` drops 2 cycles after the last fall.
- FIFO full: hold `req_valid` high while the FSM is stalled in LATCH.
  - `req_ready` goes low after 4 accepted entries; the 5th is not lost.
  - The 5th is accepted the cycle after the first pop.
- Broadcast: section 01, `req_broadcast`=1, target field 9.
  - 16 pulses with `cmd_data[29:26]`=0..15 in order.
  - `issued_count`=16.
  - Only one FIFO entry consumed.
- Run broadcast: section 11, target 4'b1010, `req_broadcast`=1 → exactly one pulse with `cmd_data[31:26]`=6'b111010.
- Reset mid-pulse: assert `reset_n`=0 while `latch_data` is high.
  - `latch_data`, `cmd_data` and `issued_count` go to 0 without waiting for a clock edge.
  - Queued entries discarded; `req_ready`=1.
